player_damage: RTL and testbench
================================

Name: player_damage

Overview:
Receiving end of the enemy attack interface. It takes each enemy's Enemy_Attack_Ready, alive flag and position, applies a wind-up delay per enemy, and arbitrates strikes against the player. It maintains player HP, an invulnerability window after each hit, and the death state. It sits beside the enemy instances in the top level and feeds the HUD, the player sprite blink and game-over logic.

Parameters:
N_ENEMY, 4, number of enemy instances
MAX_HP, 100, player HP after reset
DAMAGE, 10, HP removed per hit
WINDUP, 3, frames of continuous ready and in-range before a strike
INVULN, 30, frames of invulnerability after a hit
ATTACK_RANGE, 2, pixel margin added around the enemy box for the range test

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  reset, asynchronous, active-low
frame_clk  in  1  raw frame clock, about 60 Hz; edge-detected internally
Enemy_Attack_Ready  in  N_ENEMY  per-enemy "stopped next to player"
Enemy_Alive  in  N_ENEMY  per-enemy alive flag
Enemy_X  in  9*N_ENEMY  enemy top-left X, enemy i at bits [9i+8:9i]
Enemy_Y  in  9*N_ENEMY  enemy top-left Y, same packing
Player_X, Player_Y  in  9 each  player top-left
Player_HP  out  8  current HP
Player_Hit  out  1  one-Clk pulse when a hit lands
Hit_Enemy_Id  out  2  index of the last enemy that landed a hit
Player_Invuln  out  1  high during the invulnerability window
Player_Flash  out  1  sprite blink enable
Player_Dead  out  1  latched game over

Behaviour:
- frame_tick: frame_clk registered twice. The tick is one Clk wide and appears 2 Clk after the frame_clk rising edge. All frame-rate state updates only on frame_tick.
- Reset (Reset_n low, asynchronous) sets:
  - Player_HP = MAX_HP
  - Player_Hit = 0, Hit_Enemy_Id = 0
  - Player_Invuln = 0, Player_Flash = 0, Player_Dead = 0
  - FSM state ALIVE
  - all wind-up counters = 0, invulnerability counter = 0
  - Reset mid-window or mid-wind-up aborts everything.
- Range test for enemy i. Compute in 10 bits with no wrap. Enemy box is 26x26, player box is 18x20, R = ATTACK_RANGE. In range when all four hold:
  - Ex <= Px+18+R
  - Px <= Ex+26+R
  - Ey <= Py+20+R
  - Py <= Ey+26+R
- cond_i = Enemy_Attack_Ready[i] AND Enemy_Alive[i] AND in-range_i.
- Wind-up counter per enemy (0..WINDUP), updated on frame_tick:
  - cond_i low → counter cleared to 0.
  - cond_i high → counter increments and saturates at WINDUP.
  - req_i = (counter == WINDUP) AND cond_i, evaluated with the pre-update counter value.
  - A granted enemy's counter is cleared to 0.
  - An ungranted request stays saturated and re-requests on later frames.
- Arbitration: lowest index with req_i wins. At most one hit per frame_tick.
- FSM states:
  - ALIVE: on frame_tick with any req:
    - HP -= DAMAGE, saturating at 0.
    - Player_Hit = 1 for the next Clk only.
    - Hit_Enemy_Id = winner.
    - Invulnerability counter = INVULN.
    - New HP == 0 → go to DEAD; otherwise go to INVULN.
  - INVULN:
    - Requests are ignored; counters keep counting and saturating.
    - Each frame_tick decrements the invulnerability counter.
    - Moving from count 1 to 0 returns to ALIVE. The first hit is possible on the following frame_tick.
    - Player_Invuln = 1.
    - Player_Flash = bit 2 of the invulnerability counter.
  - DEAD:
    - Terminal until reset.
    - Player_Dead = 1, HP = 0.
    - Counters hold, no hits, Player_Invuln = 0, Player_Flash = 0.
- ALIVE outputs: Player_Invuln = 0, Player_Flash = 0.
- Boundaries:
  - HP < DAMAGE → HP = 0 and DEAD.
  - An enemy dying mid-wind-up clears its counter on the next frame_tick.
  - If WINDUP = 0, req_i = cond_i.
  - Simultaneous requests from all enemies cause one hit only (lowest index).

Decomposition:
- Shared package boxhead_pkg holds:
  - coordinate typedef (logic [8:0])
  - ENEMY_W/H = 26, PLAYER_W = 18, PLAYER_H = 20
  - damage_state_t enum {ALIVE, INVULN, DEAD}
- One sub-module, attack_windup: range test plus saturating counter for one enemy. It is instantiated N_ENEMY times in a generate loop, with inputs cond, frame_tick and grant, and output req.

Test Plan:
- Enemy 0 at (100,100), player at (120,100), ready and alive held → first hit on the 4th frame_tick (WINDUP=3), HP 100→90, Player_Hit high for 1 Clk, Hit_Enemy_Id = 0.
- After that hit, keep ready held → Player_Invuln high for 30 frames, Player_Flash toggles every 4 frames, next hit lands on frame 31 after the first, HP → 80.
- Enemies 1 and 3 both saturated on the same tick → exactly one hit, Hit_Enemy_Id = 1; enemy 3 hits after the invulnerability window ends.
- Enemy ready but at (200,100) with player at (120,100) (out of range), or Enemy_Alive = 0 → no hit for 100 frames, HP stays 100.
- Ten hits → HP reaches 0, Player_Dead = 1; further requests cause no Player_Hit.
- Assert Reset_n low mid-INVULN with HP = 40 → HP = 100, Invuln = 0, counters = 0 immediately, without waiting for a Clk edge.

Source files
------------

// File: rtl/boxhead_pkg.sv
// Shared types and geometry for the player/enemy interaction logic.
package boxhead_pkg;

   typedef logic [8:0] coord_t;

   localparam int unsigned ENEMY_W  = 26;
   localparam int unsigned ENEMY_H  = 26;
   localparam int unsigned PLAYER_W = 18;
   localparam int unsigned PLAYER_H = 20;

   typedef enum logic [1:0] {StAlive, StInvuln, StDead} damage_state_t;

   // Box-overlap test with a margin; 10-bit sums so edge-of-screen boxes never wrap.
   function automatic logic in_range(coord_t ex, coord_t ey, coord_t px, coord_t py,
                                     logic [9:0] r);
      logic [9:0] w_ex, w_ey, w_px, w_py;
      w_ex = {1'b0, ex};
      w_ey = {1'b0, ey};
      w_px = {1'b0, px};
      w_py = {1'b0, py};
      return (w_ex <= w_px + 10'(PLAYER_W) + r) &&
             (w_px <= w_ex + 10'(ENEMY_W) + r) &&
             (w_ey <= w_py + 10'(PLAYER_H) + r) &&
             (w_py <= w_ey + 10'(ENEMY_H) + r);
   endfunction

endpackage

// File: rtl/attack_windup.sv
// Per-enemy range test and saturating wind-up counter; raises req once the enemy
// has been ready, alive and in range for WINDUP consecutive frames.
module attack_windup
   import boxhead_pkg::*;
#(
   parameter int unsigned WINDUP       = 3,
   parameter int unsigned ATTACK_RANGE = 2
) (
   input  logic   Clk,
   input  logic   Reset_n,
   input  logic   i_frame_tick,
   input  logic   i_hold,
   input  logic   i_grant,
   input  logic   i_ready,
   input  logic   i_alive,
   input  coord_t i_enemy_x,
   input  coord_t i_enemy_y,
   input  coord_t i_player_x,
   input  coord_t i_player_y,
   output logic   o_req
);

   localparam int unsigned CntW = (WINDUP > 0) ? $clog2(WINDUP + 1) : 1;
   localparam logic [CntW-1:0] CntSat = CntW'(WINDUP);

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_d;
   logic            w_cond;

   assign w_cond = i_ready & i_alive &
                   in_range(i_enemy_x, i_enemy_y, i_player_x, i_player_y, 10'(ATTACK_RANGE));
   assign o_req  = w_cond & (r_cnt == CntSat);

   always_comb begin
      w_cnt_d = r_cnt;
      if (i_frame_tick && !i_hold) begin
         if (i_grant || !w_cond) begin
            w_cnt_d = '0;
         end else if (r_cnt != CntSat) begin
            w_cnt_d = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

endmodule

// File: rtl/player_damage.sv
// Player damage handler: arbitrates enemy strikes, tracks HP, the post-hit
// invulnerability window and the latched death state.
module player_damage
   import boxhead_pkg::*;
#(
   parameter int unsigned N_ENEMY      = 4,
   parameter int unsigned MAX_HP       = 100,
   parameter int unsigned DAMAGE       = 10,
   parameter int unsigned WINDUP       = 3,
   parameter int unsigned INVULN       = 30,
   parameter int unsigned ATTACK_RANGE = 2,
   localparam int unsigned IdW         = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   frame_clk,
   input  logic [N_ENEMY-1:0]     Enemy_Attack_Ready,
   input  logic [N_ENEMY-1:0]     Enemy_Alive,
   input  logic [9*N_ENEMY-1:0]   Enemy_X,
   input  logic [9*N_ENEMY-1:0]   Enemy_Y,
   input  coord_t                 Player_X,
   input  coord_t                 Player_Y,
   output logic [7:0]             Player_HP,
   output logic                   Player_Hit,
   output logic [IdW-1:0]         Hit_Enemy_Id,
   output logic                   Player_Invuln,
   output logic                   Player_Flash,
   output logic                   Player_Dead
);

   localparam int unsigned InvW = ($clog2(INVULN + 1) > 3) ? $clog2(INVULN + 1) : 3;
   localparam logic [7:0]  Dmg  = 8'(DAMAGE);

   damage_state_t    r_state, w_state_d;
   logic [7:0]       r_hp, w_hp_d;
   logic [InvW-1:0]  r_inv, w_inv_d;
   logic             r_hit, w_hit_d;
   logic [IdW-1:0]   r_id, w_id_d, w_winner;
   logic [2:0]       r_fc;
   logic             w_frame_tick, w_take, w_hold;
   logic [N_ENEMY-1:0] w_req, w_grant;

   // Two synchroniser stages plus one for edge detection.
   assign w_frame_tick = r_fc[1] & ~r_fc[2];
   assign w_hold       = (r_state == StDead);
   assign w_grant      = w_take ? (N_ENEMY'(1) << w_winner) : '0;

   for (genvar g = 0; g < N_ENEMY; g++) begin : g_windup
      attack_windup #(
         .WINDUP       (WINDUP),
         .ATTACK_RANGE (ATTACK_RANGE)
      ) u_windup (
         .Clk          (Clk),
         .Reset_n      (Reset_n),
         .i_frame_tick (w_frame_tick),
         .i_hold       (w_hold),
         .i_grant      (w_grant[g]),
         .i_ready      (Enemy_Attack_Ready[g]),
         .i_alive      (Enemy_Alive[g]),
         .i_enemy_x    (Enemy_X[9*g +: 9]),
         .i_enemy_y    (Enemy_Y[9*g +: 9]),
         .i_player_x   (Player_X),
         .i_player_y   (Player_Y),
         .o_req        (w_req[g])
      );
   end

   always_comb begin
      w_winner = '0;
      for (int i = N_ENEMY - 1; i >= 0; i--) begin
         if (w_req[i]) w_winner = IdW'(i);
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_hp_d    = r_hp;
      w_inv_d   = r_inv;
      w_hit_d   = 1'b0;
      w_id_d    = r_id;
      w_take    = 1'b0;
      unique case (r_state)
         StAlive: begin
            if (w_frame_tick && (|w_req)) begin
               w_take    = 1'b1;
               w_hp_d    = (r_hp < Dmg) ? 8'd0 : r_hp - Dmg;
               w_hit_d   = 1'b1;
               w_id_d    = w_winner;
               w_inv_d   = InvW'(INVULN);
               w_state_d = (w_hp_d == 8'd0) ? StDead : StInvuln;
            end
         end
         StInvuln: begin
            if (w_frame_tick) begin
               w_inv_d = (r_inv != '0) ? r_inv - 1'b1 : '0;
               if (r_inv <= InvW'(1)) w_state_d = StAlive;
            end
         end
         StDead: begin
            w_hp_d = 8'd0;
         end
         default: w_state_d = StAlive;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fc    <= '0;
         r_state <= StAlive;
         r_hp    <= 8'(MAX_HP);
         r_inv   <= '0;
         r_hit   <= 1'b0;
         r_id    <= '0;
      end else begin
         r_fc    <= {r_fc[1:0], frame_clk};
         r_state <= w_state_d;
         r_hp    <= w_hp_d;
         r_inv   <= w_inv_d;
         r_hit   <= w_hit_d;
         r_id    <= w_id_d;
      end
   end

   assign Player_HP     = r_hp;
   assign Player_Hit    = r_hit;
   assign Hit_Enemy_Id  = r_id;
   assign Player_Invuln = (r_state == StInvuln);
   assign Player_Flash  = (r_state == StInvuln) & r_inv[2];
   assign Player_Dead   = (r_state == StDead);

endmodule

// File: tb/tb_player_damage.sv
// Self-checking bench for player_damage: directed scenarios plus random frames,
// all checked against a frame-level behavioural model.
module tb_player_damage;

   localparam int N     = 4;
   localparam int MAXHP = 100;
   localparam int DMG   = 10;
   localparam int WU    = 3;
   localparam int INV   = 30;
   localparam int RNG   = 2;

   logic           Clk = 1'b0;
   logic           Reset_n;
   logic           frame_clk;
   logic [N-1:0]   Enemy_Attack_Ready;
   logic [N-1:0]   Enemy_Alive;
   logic [9*N-1:0] Enemy_X;
   logic [9*N-1:0] Enemy_Y;
   logic [8:0]     Player_X;
   logic [8:0]     Player_Y;
   logic [7:0]     Player_HP;
   logic           Player_Hit;
   logic [1:0]     Hit_Enemy_Id;
   logic           Player_Invuln;
   logic           Player_Flash;
   logic           Player_Dead;

   player_damage u_dut (
      .Clk                (Clk),
      .Reset_n            (Reset_n),
      .frame_clk          (frame_clk),
      .Enemy_Attack_Ready (Enemy_Attack_Ready),
      .Enemy_Alive        (Enemy_Alive),
      .Enemy_X            (Enemy_X),
      .Enemy_Y            (Enemy_Y),
      .Player_X           (Player_X),
      .Player_Y           (Player_Y),
      .Player_HP          (Player_HP),
      .Player_Hit         (Player_Hit),
      .Hit_Enemy_Id       (Hit_Enemy_Id),
      .Player_Invuln      (Player_Invuln),
      .Player_Flash       (Player_Flash),
      .Player_Dead        (Player_Dead)
   );

   always #5 Clk = ~Clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Stimulus state
   int rdy[N], alv[N], ex[N], ey[N];
   int px, py;

   // Model state: frames of invulnerability left, per-enemy consecutive-ready frames
   int m_hp, m_inv, m_dead, m_id;
   int m_wind[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < N; i++) begin
         Enemy_Attack_Ready[i] = (rdy[i] != 0);
         Enemy_Alive[i]        = (alv[i] != 0);
         Enemy_X[9*i +: 9]     = 9'(ex[i]);
         Enemy_Y[9*i +: 9]     = 9'(ey[i]);
      end
      Player_X = 9'(px);
      Player_Y = 9'(py);
   endtask

   task automatic model_reset();
      m_hp   = MAXHP;
      m_inv  = 0;
      m_dead = 0;
      m_id   = 0;
      for (int i = 0; i < N; i++) m_wind[i] = 0;
   endtask

   function automatic bit near(int i);
      return (ex[i] <= px + 18 + RNG) && (px <= ex[i] + 26 + RNG) &&
             (ey[i] <= py + 20 + RNG) && (py <= ey[i] + 26 + RNG);
   endfunction

   task automatic model_tick(output int exp_hit);
      bit c[N];
      int win;
      win     = -1;
      exp_hit = 0;
      for (int i = 0; i < N; i++) c[i] = (rdy[i] != 0) && (alv[i] != 0) && near(i);
      if (m_dead == 0) begin
         if (m_inv > 0) begin
            m_inv--;
         end else begin
            for (int i = 0; i < N; i++)
               if (win < 0 && c[i] && m_wind[i] >= WU) win = i;
         end
         if (win >= 0) begin
            exp_hit = 1;
            m_hp    = (m_hp > DMG) ? m_hp - DMG : 0;
            m_id    = win;
            m_inv   = INV;
            if (m_hp == 0) m_dead = 1;
         end
         for (int i = 0; i < N; i++) begin
            if (i == win || !c[i]) m_wind[i] = 0;
            else if (m_wind[i] < WU) m_wind[i]++;
         end
      end
   endtask

   task automatic check_state(input string tag);
      int inv_on;
      inv_on = (m_dead == 0 && m_inv > 0) ? 1 : 0;
      chk({tag, "_hp"},     32'(Player_HP),     32'(m_hp));
      chk({tag, "_id"},     32'(Hit_Enemy_Id),  32'(m_id));
      chk({tag, "_invuln"}, 32'(Player_Invuln), 32'(inv_on));
      chk({tag, "_flash"},  32'(Player_Flash),  32'(inv_on != 0 ? (m_inv >> 2) & 1 : 0));
      chk({tag, "_dead"},   32'(Player_Dead),   32'(m_dead));
   endtask

   // One frame: frame_clk high 4 Clk then low 4 Clk; Player_Hit counted every Clk.
   task automatic frame(input string tag);
      int exp_hit, hits;
      model_tick(exp_hit);
      hits = 0;
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         if (Player_Hit) hits++;
      end
      frame_clk = 1'b0;
      repeat (4) begin
         @(negedge Clk);
         if (Player_Hit) hits++;
      end
      chk({tag, "_hitpulse"}, 32'(hits), 32'(exp_hit));
      check_state(tag);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic clear_enemies();
      for (int i = 0; i < N; i++) begin
         rdy[i] = 0;
         alv[i] = 1;
         ex[i]  = 400;
         ey[i]  = 400;
      end
   endtask

   initial begin
      frame_clk = 1'b0;
      Reset_n   = 1'b0;
      px = 120;
      py = 100;
      clear_enemies();
      apply_inputs();
      model_reset();
      #7;
      chk("rst_hp",     32'(Player_HP),     32'd100);
      chk("rst_hit",    32'(Player_Hit),    32'd0);
      chk("rst_id",     32'(Hit_Enemy_Id),  32'd0);
      chk("rst_invuln", 32'(Player_Invuln), 32'd0);
      chk("rst_flash",  32'(Player_Flash),  32'd0);
      chk("rst_dead",   32'(Player_Dead),   32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Enemy 0 adjacent and ready: hit on 4th tick, then every 31 ticks
      rdy[0] = 1; ex[0] = 100; ey[0] = 100;
      apply_inputs();
      repeat (4) frame("s1");
      chk("s1_first_hp", 32'(Player_HP), 32'd90);
      repeat (32) frame("s1");
      chk("s1_second_hp", 32'(Player_HP), 32'd80);
      repeat (128) frame("s1");
      chk("s1_mid_hp",     32'(Player_HP),     32'd40);
      chk("s1_mid_invuln", 32'(Player_Invuln), 32'd1);

      // Asynchronous reset in the middle of the window
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      chk("arst_hp",     32'(Player_HP),     32'd100);
      chk("arst_invuln", 32'(Player_Invuln), 32'd0);
      chk("arst_flash",  32'(Player_Flash),  32'd0);
      chk("arst_dead",   32'(Player_Dead),   32'd0);
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (4) frame("arst");
      chk("arst_rehit_hp", 32'(Player_HP), 32'd90);

      // Enemies 1 and 3 saturate together: 1 wins, 3 after the window
      do_reset();
      clear_enemies();
      rdy[1] = 1; ex[1] = 110; ey[1] = 105;
      rdy[3] = 1; ex[3] = 130; ey[3] = 95;
      apply_inputs();
      repeat (4) frame("s3");
      chk("s3_first_id", 32'(Hit_Enemy_Id), 32'd1);
      rdy[1] = 0;
      apply_inputs();
      repeat (31) frame("s3");
      chk("s3_second_id", 32'(Hit_Enemy_Id), 32'd3);
      chk("s3_hp",        32'(Player_HP),    32'd80);

      // Out of range, or not alive: never hits
      do_reset();
      clear_enemies();
      rdy[0] = 1; ex[0] = 200; ey[0] = 100;
      rdy[2] = 1; alv[2] = 0; ex[2] = 120; ey[2] = 100;
      apply_inputs();
      repeat (100) frame("s4");
      chk("s4_hp", 32'(Player_HP), 32'd100);

      // Ten hits to death, then all enemies striking has no effect
      do_reset();
      clear_enemies();
      rdy[0] = 1; ex[0] = 100; ey[0] = 100;
      apply_inputs();
      repeat (290) frame("s5");
      chk("s5_dead", 32'(Player_Dead), 32'd1);
      chk("s5_hp",   32'(Player_HP),   32'd0);
      for (int i = 0; i < N; i++) begin
         rdy[i] = 1; ex[i] = 110 + i; ey[i] = 100;
      end
      apply_inputs();
      repeat (20) frame("s5_post");

      // Random enemy behaviour around a fixed player
      do_reset();
      px = 200;
      py = 200;
      for (int i = 0; i < N; i++) begin
         ex[i] = 200; ey[i] = 200; rdy[i] = 1; alv[i] = 1;
      end
      for (int f = 0; f < 300; f++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               ex[i]  = px + int'($urandom_range(0, 64)) - 32;
               ey[i]  = py + int'($urandom_range(0, 64)) - 32;
               rdy[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
               alv[i] = ($urandom_range(0, 7) != 0) ? 1 : 0;
            end
         end
         apply_inputs();
         frame("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
